uart_frame_ctrl: RTL and testbench
==================================

Name: uart_frame_ctrl

Overview:
Command-frame controller placed after the UART byte receiver. It consumes the receiver's one-cycle Rx_Done strobe and the byte on data_byte, and parses fixed 6-byte frames. Valid frames update the LED-control registers and the receiver's baud_set configuration. Corrupt, unknown or stalled frames are discarded and counted.

Parameters:
TIMEOUT_CYC, 500000, inter-byte timeout in Clk cycles while mid-frame (10 ms at 50 MHz); must be at least 2.
CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.
DEF_BLINK, 16'd25000, reset value of blink_period.

Ports:
Clk  input  1  module clock, 50 MHz.
Rst_n  input  1  reset, asynchronous, active-low.
Rx_Done  input  1  one-cycle strobe: data_byte holds a new byte this cycle.
data_byte  input  8  received byte, valid only while Rx_Done=1.
baud_set  output  3  baud selection fed back to the receiver (0..4 legal).
led_mode  output  8  LED pattern register.
blink_period  output  16  LED blink period register.
cmd_valid  output  1  one-cycle pulse: a frame was accepted and executed.
frame_err  output  1  one-cycle pulse: a frame was discarded.
err_cnt  output  8  saturating count of discarded frames.

Behaviour:
- Reset is asynchronous and active-low. Reset values: state=S_IDLE, baud_set=0, led_mode=0, blink_period=DEF_BLINK, cmd_valid=0, frame_err=0, err_cnt=0, timeout counter=0, shadow regs=0.
- Frame format: 0x55, 0xA5, CMD, DH, DL, CHK.
- CHK = (CMD+DH+DL) mod 256, computed as an 8-bit sum with the carry dropped.
- The FSM advances only on cycles where Rx_Done=1:
  - S_IDLE: byte 0x55 -> S_HDR2; any other byte -> stay in S_IDLE, no error.
  - S_HDR2: 0xA5 -> S_CMD; 0x55 -> stay in S_HDR2 (resync); other -> S_IDLE, no error.
  - S_CMD -> S_DH -> S_DL -> S_CHK: each state latches its byte into a shadow register.
  - S_CHK: compare the byte against the checksum, then always return to S_IDLE.
- Execute, on the Rx_Done edge of the CHK byte, only if the checksum matches:
  - CMD 0x01: led_mode <= DL.
  - CMD 0x02: blink_period <= {DH,DL}; a value of 0 is rejected.
  - CMD 0x03: baud_set <= DL[2:0] if DL <= 4; else rejected.
  - Any other CMD: rejected.
- On success, the outputs update on that edge and cmd_valid=1 in the following cycle (registered, latency 1 from the CHK Rx_Done).
- Rejection (bad checksum, bad CMD, illegal value): registers unchanged, frame_err=1 one cycle after the CHK Rx_Done, err_cnt+1.
- err_cnt saturates at 255.
- cmd_valid and frame_err are never high together.
- Timeout counter:
  - Cleared on every Rx_Done and whenever state=S_IDLE.
  - Increments each cycle in any other state.
  - When it reaches TIMEOUT_CYC-1 with no Rx_Done that cycle: state -> S_IDLE, frame_err pulse, err_cnt+1, counter cleared.
  - If Rx_Done and the timeout coincide, Rx_Done wins and no timeout occurs.
- Changing baud_set takes effect immediately. The controller does not wait for the line; the host must pause before sending at the new rate.
- Reset mid-frame discards the partial frame with no error pulse.
- Rx_Done held high for multiple cycles is treated as multiple bytes; the upstream receiver guarantees single-cycle strobes.

Test Plan:
1. After reset, send 55 A5 01 00 3C 3D -> led_mode=0x3C; cmd_valid high exactly 1 cycle, 1 cycle after the last Rx_Done; err_cnt=0.
2. Send 55 A5 02 61 A8 0B -> blink_period=0x61A8. Then send 55 A5 02 00 00 02 -> rejected: blink_period stays 0x61A8, frame_err pulse, err_cnt=1.
3. Send 55 A5 03 00 02 05 -> baud_set=2. Then send 55 A5 03 00 07 0A -> baud_set stays 2, frame_err pulse.
4. Send 55 A5 01 00 3C 3E (bad checksum) -> led_mode unchanged, frame_err pulse. Then send a garbage prefix 12 55 55 A5 01 00 11 12 -> led_mode=0x11 with no extra error.
5. With TIMEOUT_CYC=100: send 55 A5 01 then idle -> frame_err exactly 99 cycles after the 01 strobe. A following full frame is accepted. Separately, a byte arriving on that exact cycle prevents the timeout.
6. Send 260 bad-checksum frames -> err_cnt=255. Assert Rst_n=0 mid-frame -> all outputs return to reset values immediately, with no pulses.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses 6-byte 55 A5 CMD DH DL CHK frames from the UART receiver
// and drives the LED registers and receiver baud selection.
module uart_frame_ctrl #(
  parameter int          TIMEOUT_CYC = 500000,
  parameter int          CNT_W       = 20,
  parameter logic [15:0] DEF_BLINK   = 16'd25000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Rx_Done,
  input  logic [7:0]  data_byte,
  output logic [2:0]  baud_set,
  output logic [7:0]  led_mode,
  output logic [15:0] blink_period,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR2 = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_DH   = 3'd3;
  localparam logic [2:0] S_DL   = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;
  logic [2:0]       state, nxt;
  logic [7:0]       cmd_r, dh_r, dl_r, sum;
  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout, done_chk, cmd_ok, accept, reject;
  // fires on the cycle the counter would step to TIMEOUT_CYC-1; a byte that cycle wins
  assign timeout  = state != S_IDLE && !Rx_Done && tmo_cnt == CNT_W'(TIMEOUT_CYC - 2);
  assign sum      = cmd_r + dh_r + dl_r;
  assign done_chk = Rx_Done && state == S_CHK;
  assign cmd_ok   = cmd_r == 8'h01 || (cmd_r == 8'h02 && {dh_r, dl_r} != 16'd0) ||
                    (cmd_r == 8'h03 && dl_r <= 8'd4);
  assign accept   = done_chk && data_byte == sum && cmd_ok;
  assign reject   = (done_chk && !accept) || timeout;
  always_comb begin
    nxt = state;
    if (Rx_Done)
      case (state)
        S_IDLE:  nxt = data_byte == 8'h55 ? S_HDR2 : S_IDLE;
        S_HDR2:  nxt = data_byte == 8'hA5 ? S_CMD : data_byte == 8'h55 ? S_HDR2 : S_IDLE;
        S_CMD:   nxt = S_DH;
        S_DH:    nxt = S_DL;
        S_DL:    nxt = S_CHK;
        default: nxt = S_IDLE;
      endcase
    else if (timeout)
      nxt = S_IDLE;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= S_IDLE;
      tmo_cnt      <= '0;
      cmd_r        <= '0;
      dh_r         <= '0;
      dl_r         <= '0;
      baud_set     <= '0;
      led_mode     <= '0;
      blink_period <= DEF_BLINK;
      cmd_valid    <= 1'b0;
      frame_err    <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state     <= nxt;
      tmo_cnt   <= (Rx_Done || state == S_IDLE || timeout) ? '0 : tmo_cnt + 1'b1;
      cmd_valid <= accept;
      frame_err <= reject;
      if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      if (Rx_Done && state == S_CMD) cmd_r <= data_byte;
      if (Rx_Done && state == S_DH) dh_r <= data_byte;
      if (Rx_Done && state == S_DL) dl_r <= data_byte;
      if (accept && cmd_r == 8'h01) led_mode <= dl_r;
      if (accept && cmd_r == 8'h02) blink_period <= {dh_r, dl_r};
      if (accept && cmd_r == 8'h03) baud_set <= dl_r[2:0];
    end
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: scoreboard bench; each frame pushes its expected pulse and
// register state, popped when cmd_valid or frame_err appears.
module tb_uart_frame_ctrl;
  logic        Clk, Rst_n, Rx_Done;
  logic [7:0]  data_byte;
  logic [2:0]  baud_set;
  logic [7:0]  led_mode, err_cnt;
  logic [15:0] blink_period;
  logic        cmd_valid, frame_err;
  uart_frame_ctrl #(.TIMEOUT_CYC(100), .CNT_W(20), .DEF_BLINK(16'd25000)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rx_Done(Rx_Done), .data_byte(data_byte),
    .baud_set(baud_set), .led_mode(led_mode), .blink_period(blink_period),
    .cmd_valid(cmd_valid), .frame_err(frame_err), .err_cnt(err_cnt)
  );
  typedef struct {
    logic        ok;
    logic [7:0]  led;
    logic [15:0] blink;
    logic [2:0]  baud;
    logic [7:0]  err;
    int          cyc;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [7:0]  m_led, m_err;
  logic [15:0] m_blink;
  logic [2:0]  m_baud;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge Clk) if (Rst_n === 1'b1 && (cmd_valid || frame_err)) begin
    chk("exclusive", {31'd0, cmd_valid & frame_err}, 0);
    if (q.size() == 0) chk("unexpected_pulse", {30'd0, cmd_valid, frame_err}, 0);
    else begin
      e = q.pop_front();
      chk("kind_cmd_valid", {31'd0, cmd_valid}, {31'd0, e.ok});
      chk("latency", cyc, e.cyc);
      chk("led_mode", {24'd0, led_mode}, {24'd0, e.led});
      chk("blink_period", {16'd0, blink_period}, {16'd0, e.blink});
      chk("baud_set", {29'd0, baud_set}, {29'd0, e.baud});
      chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.err});
    end
  end
  task automatic send_byte(input logic [7:0] b);
    @(posedge Clk);
    #1 Rx_Done = 1'b1;
    data_byte = b;
    @(posedge Clk);
    #1 Rx_Done = 1'b0;
    data_byte = 8'h00;
  endtask
  task automatic model_reset();
    m_led = 8'h00; m_blink = 16'd25000; m_baud = 3'd0; m_err = 8'h00;
  endtask
  task automatic push_err(input int at);
    if (m_err != 8'hFF) m_err++;
    q.push_back('{1'b0, m_led, m_blink, m_baud, m_err, at});
  endtask
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] ck);
    logic ok;
    send_byte(8'h55); send_byte(8'hA5); send_byte(cmd); send_byte(dh); send_byte(dl);
    ok = ck == 8'(cmd + dh + dl) &&
         (cmd == 8'h01 || (cmd == 8'h02 && {dh, dl} != 16'd0) || (cmd == 8'h03 && dl <= 8'd4));
    send_byte(ck);
    if (!ok) push_err(cyc);
    else begin
      if (cmd == 8'h01) m_led = dl;
      if (cmd == 8'h02) m_blink = {dh, dl};
      if (cmd == 8'h03) m_baud = dl[2:0];
      q.push_back('{1'b1, m_led, m_blink, m_baud, m_err, cyc});
    end
  endtask
  task automatic check_regs(input string tag);
    repeat (3) @(posedge Clk);
    #1;
    chk({tag, "_led"}, {24'd0, led_mode}, {24'd0, m_led});
    chk({tag, "_blink"}, {16'd0, blink_period}, {16'd0, m_blink});
    chk({tag, "_baud"}, {29'd0, baud_set}, {29'd0, m_baud});
    chk({tag, "_err"}, {24'd0, err_cnt}, {24'd0, m_err});
  endtask
  initial begin
    Rst_n = 1'b0; Rx_Done = 1'b0; data_byte = 8'h00;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_led", {24'd0, led_mode}, 0);
    chk("rst_blink", {16'd0, blink_period}, 32'd25000);
    chk("rst_baud", {29'd0, baud_set}, 0);
    chk("rst_err", {24'd0, err_cnt}, 0);
    chk("rst_pulses", {30'd0, cmd_valid, frame_err}, 0);
    Rst_n = 1'b1;
    send_frame(8'h01, 8'h00, 8'h3C, 8'h3D);
    check_regs("t1");
    send_frame(8'h02, 8'h61, 8'hA8, 8'h0B);
    send_frame(8'h02, 8'h00, 8'h00, 8'h02);
    check_regs("t2");
    send_frame(8'h03, 8'h00, 8'h02, 8'h05);
    send_frame(8'h03, 8'h00, 8'h07, 8'h0A);
    check_regs("t3");
    send_frame(8'h01, 8'h00, 8'h3C, 8'h3E);
    send_byte(8'h12); send_byte(8'h55);
    send_frame(8'h01, 8'h00, 8'h11, 8'h12);
    check_regs("t4");
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h01);
    push_err(cyc + 99);
    repeat (110) @(posedge Clk);
    send_frame(8'h01, 8'h00, 8'h22, 8'h23);
    check_regs("t5a");
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h01);
    repeat (97) @(posedge Clk);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h45);
    m_led = 8'h44;
    q.push_back('{1'b1, m_led, m_blink, m_baud, m_err, cyc});
    check_regs("t5b");
    for (int i = 0; i < 260; i++) send_frame(8'h01, 8'h00, 8'h01, 8'h00);
    check_regs("t6");
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h01);
    #3 Rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_led", {24'd0, led_mode}, 0);
    chk("arst_blink", {16'd0, blink_period}, 32'd25000);
    chk("arst_baud", {29'd0, baud_set}, 0);
    chk("arst_err", {24'd0, err_cnt}, 0);
    chk("arst_pulses", {30'd0, cmd_valid, frame_err}, 0);
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    repeat (120) @(posedge Clk);
    send_frame(8'h01, 8'h00, 8'h3C, 8'h3D);
    check_regs("t7");
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge Clk);
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
